// File: rtl/router_pkg.sv
// Shared router constants: port count, index width, arbiter state encoding
// and the idle levels driven onto an output link.
package router_pkg;

    localparam int unsigned N_PORTS = 16;
    localparam int unsigned ADDR_W  = 4;

    // Pointer value after reset: the search starts at ptr+1, so input 0 is first.
    localparam logic [ADDR_W-1:0] PTR_RESET = ADDR_W'(N_PORTS - 1);

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    // One serial link: active-low frame, active-low valid, data bit.
    typedef struct packed {
        logic frame_n;
        logic valid_n;
        logic data;
    } link_t;

    localparam link_t LINK_IDLE = '{frame_n: 1'b1, valid_n: 1'b1, data: 1'b0};

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr+1, wrapping modulo
// N_PORTS. Purely combinational.
module rr_pick
    import router_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [ADDR_W-1:0]  ptr,
    output logic [N_PORTS-1:0] pick_onehot,
    output logic [ADDR_W-1:0]  pick_idx
);

    logic [ADDR_W-1:0] cand;

    // Scan from farthest (ptr+16 == ptr) to nearest (ptr+1); the last hit wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        pick_idx = '0;
        cand     = '0;
        for (int i = N_PORTS; i >= 1; i--) begin
            cand = ptr + ADDR_W'(i);
            if (req[cand]) begin
                pick_idx = cand;
            end
        end
        pick_onehot = (|req) ? (N_PORTS'(1) << pick_idx) : '0;
    end

endmodule

// File: rtl/port_arbiter.sv
// Output-port arbiter: round-robin grant among 16 inputs, registered
// forwarding of the granted input's serial link, one-cycle inter-frame gap
// and an optional hold watchdog.
module port_arbiter #(
    parameter int unsigned MAX_HOLD = 0,
    parameter int unsigned N_PORTS  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_PORTS-1:0]            req,
    input  logic [N_PORTS-1:0]            frame_n,
    input  logic [N_PORTS-1:0]            valid_n,
    input  logic [N_PORTS-1:0]            din,
    output logic [N_PORTS-1:0]            grant,
    output logic [router_pkg::ADDR_W-1:0] grant_id,
    output logic                          busy,
    output logic                          frame_o,
    output logic                          valid_o,
    output logic                          dout,
    output logic                          timeout
);

    import router_pkg::*;

    localparam int unsigned HOLD_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST_V = HOLD_W'(HOLD_LAST);

    arb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [N_PORTS-1:0]  grant_q, grant_d;
    logic [ADDR_W-1:0]   grant_id_q, grant_id_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    link_t               link_q, link_d;
    logic                timeout_q, timeout_d;

    logic [N_PORTS-1:0]  pick_onehot;
    logic [ADDR_W-1:0]   pick_idx;
    logic [ADDR_W-1:0]   sel_idx;
    link_t               sel_link;
    logic                wd_expire;

    rr_pick u_rr_pick (
        .req         (req),
        .ptr         (ptr_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx)
    );

    // Select the input feeding the link: the new winner when leaving IDLE,
    // otherwise the held grant.
    always_comb begin
        sel_idx          = (state_q == ARB_IDLE) ? pick_idx : grant_id_q;
        sel_link.frame_n = frame_n[sel_idx];
        sel_link.valid_n = valid_n[sel_idx];
        sel_link.data    = din[sel_idx];
        wd_expire        = (MAX_HOLD != 0) && (hold_q == HOLD_LAST_V);
    end

    // Next-state and next-output computation for IDLE -> GRANT -> RELEASE.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        hold_d     = hold_q;
        link_d     = LINK_IDLE;
        timeout_d  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    state_d    = ARB_GRANT;
                    grant_d    = pick_onehot;
                    grant_id_d = pick_idx;
                    hold_d     = '0;
                    link_d     = sel_link;
                end
            end
            ARB_GRANT: begin
                hold_d = (&hold_q) ? hold_q : hold_q + HOLD_W'(1);
                if (sel_link.frame_n || wd_expire) begin
                    // Frame end and watchdog expiry together release once, with timeout.
                    state_d   = ARB_RELEASE;
                    grant_d   = '0;
                    ptr_d     = grant_id_q;
                    timeout_d = wd_expire;
                end else begin
                    link_d = sel_link;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values computed in the combinational block.
        if (!reset) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= PTR_RESET;
            grant_q    <= '0;
            grant_id_q <= '0;
            hold_q     <= '0;
            link_q     <= LINK_IDLE;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            hold_q     <= hold_d;
            link_q     <= link_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != ARB_IDLE);
    assign frame_o  = link_q.frame_n;
    assign valid_o  = link_q.valid_n;
    assign dout     = link_q.data;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Scoreboard bench for port_arbiter: stimulus pushes expected frames and
// payload bits, a negedge monitor pops and compares what the DUT presents.
module tb_port_arbiter;

    localparam int WD = 8;

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic [15:0] frame_n;
    logic [15:0] valid_n;
    logic [15:0] din;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic        busy;
    logic        frame_o;
    logic        valid_o;
    logic        dout;
    logic        timeout;

    port_arbiter #(.MAX_HOLD(WD), .N_PORTS(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .frame_n  (frame_n),
        .valid_n  (valid_n),
        .din      (din),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .frame_o  (frame_o),
        .valid_o  (valid_o),
        .dout     (dout),
        .timeout  (timeout)
    );

    typedef struct {
        int   id;
        int   len;
        int   flow;
        logic tmo;
        logic busy;
        int   gap;
    } frame_t;

    frame_t exp_frames[$];
    logic   exp_data[$];

    int n_vec = 0;
    int n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int id, input int len, input int flow,
                              input logic tmo, input logic bsy, input int gap);
        frame_t e;
        e.id = id; e.len = len; e.flow = flow; e.tmo = tmo; e.busy = bsy; e.gap = gap;
        exp_frames.push_back(e);
    endtask

    // One frame of len cycles on port p; the next edge must be the IDLE sampling edge.
    task automatic run_frame(input int p, input int len, input logic [7:0] vpat,
                             input logic [7:0] dpat, input int gap);
        push_frame(p, len, len, (len == WD), 1'b1, gap);
        frame_n[p] = 1'b0;
        for (int c = 0; c < len; c++) begin
            valid_n[p] = vpat[c];
            din[p]     = dpat[c];
            if (!vpat[c]) exp_data.push_back(dpat[c]);
            step();
            if (c == 0) check("grant_latency", 64'(grant), 64'(16'(1) << p));
        end
        frame_n[p] = 1'b1;
        valid_n[p] = 1'b1;
        din[p]     = 1'b0;
        step();
        step();
    endtask

    // Monitor: frame records on grant fall, payload bits whenever valid_o is low.
    logic        m_in_frame = 1'b0;
    logic        m_seen_fall = 1'b0;
    logic        m_held_ok;
    logic [15:0] m_grant;
    int          m_id, m_len, m_flow, m_gap, m_gap_cnt;

    initial begin : monitor
        frame_t e;
        m_gap_cnt = 0;
        forever begin
            @(negedge clk);
            if (grant != 16'h0) begin
                if (!m_in_frame) begin
                    m_in_frame = 1'b1;
                    m_grant    = grant;
                    m_id       = int'(grant_id);
                    m_len      = 0;
                    m_flow     = 0;
                    m_held_ok  = 1'b1;
                    m_gap      = m_seen_fall ? m_gap_cnt : -1;
                end
                m_len++;
                if (!frame_o) m_flow++;
                if (grant != m_grant) m_held_ok = 1'b0;
            end else begin
                if (m_in_frame) begin
                    m_in_frame  = 1'b0;
                    m_seen_fall = 1'b1;
                    m_gap_cnt   = 0;
                    if (exp_frames.size() == 0) begin
                        check("unexpected_frame", 64'(m_id), 64'hFFFF);
                    end else begin
                        e = exp_frames.pop_front();
                        check("frame_id", 64'(m_id), 64'(e.id));
                        check("frame_grant", 64'(m_grant), 64'(16'(1) << e.id));
                        check("frame_len", 64'(m_len), 64'(e.len));
                        check("frame_o_low", 64'(m_flow), 64'(e.flow));
                        check("grant_held", 64'(m_held_ok), 64'(1));
                        check("timeout", 64'(timeout), 64'(e.tmo));
                        check("release_busy", 64'(busy), 64'(e.busy));
                        check("release_idle", 64'({frame_o, valid_o, dout}), 64'(3'b110));
                        if (e.gap >= 0) check("gap", 64'(m_gap), 64'(e.gap));
                    end
                end
                m_gap_cnt++;
            end
            if (!valid_o) begin
                if (exp_data.size() == 0) check("unexpected_data", 64'(dout), 64'h2);
                else check("dout", 64'(dout), 64'(exp_data.pop_front()));
            end
        end
    end

    initial begin : stimulus
        reset   = 1'b0;
        req     = 16'h0;
        frame_n = 16'hFFFF;
        valid_n = 16'hFFFF;
        din     = 16'h0;
        step();
        step();
        check("reset_outs", 64'({grant, grant_id, busy, frame_o, valid_o, dout, timeout}),
              64'({16'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
        reset = 1'b1;
        step();

        // A request that drops before being sampled is never granted.
        req = 16'h0002;
        #3;
        req = 16'h0000;
        step();
        step();
        check("glitch_no_grant", 64'({grant, busy}), 64'h0);

        // Single 5-cycle frame on input 0.
        req = 16'h0001;
        run_frame(0, 5, 8'hFF, 8'h00, -1);
        check("busy_after_release", 64'(busy), 64'(0));

        // Input 4 payload 1,0,1,1.
        req = 16'h0010;
        run_frame(4, 4, 8'h00, 8'h0D, 2);

        // Frame end coincides with watchdog expiry on input 8.
        req = 16'h0100;
        run_frame(8, 8, 8'hF0, 8'h06, 2);
        req = 16'h0000;

        // Reset restores ptr=15; continuous 8011 requests rotate 0,4,15,0.
        reset = 1'b0;
        step();
        reset = 1'b1;
        req = 16'h8011;
        run_frame(0, 4, 8'hFF, 8'h00, -1);
        run_frame(4, 4, 8'hFF, 8'h00, 2);
        run_frame(15, 4, 8'h02, 8'h0B, 2);
        run_frame(0, 4, 8'hFF, 8'h00, 2);

        // Watchdog: input 2 never ends its frame; req[2] drops mid-grant.
        req = 16'h0024;
        push_frame(2, WD, WD, 1'b1, 1'b1, 2);
        frame_n[2] = 1'b0;
        step();
        check("wd_grant", 64'(grant), 64'(16'h0004));
        step();
        req = 16'h0020;
        repeat (WD - 2) step();
        step();
        check("timeout_pulse", 64'(timeout), 64'(1));
        step();
        check("timeout_once", 64'(timeout), 64'(0));
        run_frame(5, 3, 8'hFF, 8'h00, 2);
        frame_n[2] = 1'b1;

        // Reset in the middle of a grant to input 7 aborts without RELEASE.
        req = 16'h0080;
        push_frame(7, 3, 3, 1'b0, 1'b0, 2);
        frame_n[7] = 1'b0;
        step();
        check("grant7", 64'(grant), 64'(16'h0080));
        step();
        step();
        reset = 1'b0;
        step();
        check("abort_outs", 64'({grant, busy, frame_o, timeout}), 64'({16'h0, 1'b0, 1'b1, 1'b0}));
        reset = 1'b1;
        frame_n[7] = 1'b1;
        req = 16'h0081;
        run_frame(0, 2, 8'hFF, 8'h00, -1);
        req = 16'h0000;

        repeat (3) step();
        check("frames_pending", 64'(exp_frames.size()), 64'(0));
        check("data_pending", 64'(exp_data.size()), 64'(0));
        check("frame_open", 64'(m_in_frame), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
